// File: rtl/wb_result_arbiter.sv
// wb_result_arbiter
//
// Merges two functional-unit result streams onto the writeback path.
//   A source : single-cycle FU. It wins whenever it offers a packet, unless the
//              starvation guard has tripped.
//   B source : multi-cycle FU. Its results always go through a DEPTH-entry
//              circular FIFO (no bypass) and drain whenever A is idle.
// A starvation counter tracks consecutive A wins while B has work queued. Once
// it reaches STARVE_LIMIT, aReady_o drops for a cycle so the FIFO head drains.
//
// Ports
//   clk            : clock; all state changes on its rising edge
//   reset          : asynchronous, active-low reset
//   recoverFlag_i  : pipeline recovery flush; empties the FIFO, zeroes the output
//   aPacket_i      : A result, offered when .valid=1
//   aReady_o       : A result is taken this cycle if offered
//   bPacket_i      : B result, offered when .valid=1
//   bReady_o       : B result is enqueued this cycle if offered
//   wbPacket_o     : registered packet for the writeback control stage
//   bCount_o       : B FIFO occupancy, 0..DEPTH

`ifndef WB_PKT_SIZE
`define WB_PKT_SIZE 45
`endif

package wb_result_arbiter_pkg;

  localparam int unsigned WbPktSize = `WB_PKT_SIZE;
  localparam int unsigned PhyDestW  = 7;
  localparam int unsigned RobIdW    = 5;
  localparam int unsigned DataW     = WbPktSize - 1 - PhyDestW - RobIdW;

  typedef struct packed {
    logic                valid;
    logic [PhyDestW-1:0] phyDest;
    logic [RobIdW-1:0]   robId;
    logic [DataW-1:0]    data;
  } wbPkt;

endpackage

module wb_result_arbiter
  import wb_result_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   recoverFlag_i,
  input  wbPkt                   aPacket_i,
  output logic                   aReady_o,
  input  wbPkt                   bPacket_i,
  output logic                   bReady_o,
  output wbPkt                   wbPacket_o,
  output logic [$clog2(DEPTH):0] bCount_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);
  localparam logic [StvW-1:0] StarveMax = StvW'(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wbPkt            fifoMem [DEPTH];
  logic [PtrW-1:0] wrPtr_q,  wrPtr_d;
  logic [PtrW-1:0] rdPtr_q,  rdPtr_d;
  logic [CntW-1:0] count_q,  count_d;
  logic [StvW-1:0] starve_q, starve_d;
  wbPkt            wbPkt_q,  wbPkt_d;

  // ---------------------------------------------------------------------------
  // Status and handshakes -- readies depend on registered state only, so a pop
  // in the current cycle never frees a slot for a push in the same cycle.
  // ---------------------------------------------------------------------------
  logic fifoEmpty;
  logic fifoFull;
  logic starveMode;
  logic aAccept;
  logic bPush;
  logic bPop;

  always_comb begin
    fifoEmpty  = (count_q == '0);
    fifoFull   = (count_q == FullCount);
    starveMode = (starve_q == StarveMax) && !fifoEmpty;
  end

  assign aReady_o = !starveMode;
  assign bReady_o = !fifoFull;

  always_comb begin
    aAccept = aPacket_i.valid && aReady_o && !recoverFlag_i;
    bPush   = bPacket_i.valid && bReady_o && !recoverFlag_i;
    // The FIFO head drains only when A is not taking the slot.
    bPop    = !recoverFlag_i && !aAccept && !fifoEmpty;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    starve_d = starve_q;
    wbPkt_d  = '0;

    if (recoverFlag_i) begin
      wrPtr_d  = '0;
      rdPtr_d  = '0;
      count_d  = '0;
      starve_d = '0;
      wbPkt_d  = '0;
    end else begin
      // Pointers are power-of-two wide, so the increment wraps modulo DEPTH.
      if (bPush) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (bPop) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end

      unique case ({bPush, bPop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (aAccept) begin
        wbPkt_d = aPacket_i;
      end else if (bPop) begin
        wbPkt_d = fifoMem[rdPtr_q];
      end else begin
        wbPkt_d = '0;
      end

      // Count A wins only while B is waiting; any B drain or an empty FIFO
      // restarts the window.
      if (bPop || fifoEmpty) begin
        starve_d = '0;
      end else if (aAccept && (starve_q != StarveMax)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wbPkt_q  <= '0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wbPkt_q  <= wbPkt_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written,
  // and count/pointers are cleared by reset and recovery.
  always_ff @(posedge clk) begin
    if (bPush) begin
      fifoMem[wrPtr_q] <= bPacket_i;
    end
  end

  assign wbPacket_o = wbPkt_q;
  assign bCount_o   = count_q;

endmodule

// File: tb/tb_wb_result_arbiter.sv
module tb_wb_result_arbiter;
  import wb_result_arbiter_pkg::*;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned STARVE_LIMIT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       recoverFlag_i = 1'b0;
  wbPkt       aPacket_i = '0;
  wbPkt       bPacket_i = '0;
  wbPkt       wbPacket_o;
  logic       aReady_o;
  logic       bReady_o;
  logic [2:0] bCount_o;

  always #5 clk = ~clk;

  wb_result_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .recoverFlag_i (recoverFlag_i),
    .aPacket_i     (aPacket_i),
    .aReady_o      (aReady_o),
    .bPacket_i     (bPacket_i),
    .bReady_o      (bReady_o),
    .wbPacket_o    (wbPacket_o),
    .bCount_o      (bCount_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of pending B packets, count of A wins with B waiting,
  // and the packet expected on the output after the next edge.
  wbPkt bq[$];
  int   starve = 0;
  wbPkt expOut = '0;

  function automatic wbPkt mk(input bit v, input int dest, input int tag);
    wbPkt p;
    p         = '0;
    p.valid   = v;
    p.phyDest = 7'(dest);
    p.robId   = 5'(tag);
    p.data    = DataW'(tag * 1000 + dest);
    return p;
  endfunction

  function automatic wbPkt rnd(input bit v);
    wbPkt p;
    p.valid   = v;
    p.phyDest = 7'($urandom);
    p.robId   = 5'($urandom);
    p.data    = DataW'($urandom);
    return p;
  endfunction

  function automatic bit m_a_rdy();
    return !(starve == STARVE_LIMIT && bq.size() != 0);
  endfunction

  function automatic bit m_b_rdy();
    return bq.size() < DEPTH;
  endfunction

  task automatic model_reset();
    bq.delete();
    starve = 0;
    expOut = '0;
  endtask

  task automatic model_step(input wbPkt a, input wbPkt b, input bit rec);
    bit aRdy, bRdy, hadB;
    aRdy = m_a_rdy();
    bRdy = m_b_rdy();
    hadB = bq.size() != 0;
    if (rec) begin
      model_reset();
      return;
    end
    if (a.valid && aRdy) begin
      expOut = a;
      starve = hadB ? ((starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : starve + 1) : 0;
    end else if (hadB) begin
      expOut = bq.pop_front();
      starve = 0;
    end else begin
      expOut = '0;
      starve = 0;
    end
    if (b.valid && bRdy) bq.push_back(b);
  endtask

  // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
  task automatic do_cycle(input wbPkt a, input wbPkt b, input bit rec);
    aPacket_i     = a;
    bPacket_i     = b;
    recoverFlag_i = rec;
    model_step(a, b, rec);
    @(posedge clk);
    #1;
    aPacket_i     = '0;
    bPacket_i     = '0;
    recoverFlag_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    total++;
    if (aReady_o !== 1'b1 || bReady_o !== 1'b1 || bCount_o !== 3'd0 || wbPacket_o.valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold got aRdy=%b bRdy=%b cnt=%0d v=%b want 1 1 0 0",
               aReady_o, bReady_o, bCount_o, wbPacket_o.valid);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    total++;
    if (aReady_o !== 1'b1 || bReady_o !== 1'b1 || bCount_o !== 3'd0 || wbPacket_o !== '0) begin
      bad++;
      $display("FAIL reset_release got aRdy=%b bRdy=%b cnt=%0d pkt=%h want 1 1 0 0",
               aReady_o, bReady_o, bCount_o, wbPacket_o);
    end
  endtask

  task automatic test_latency();
    do_cycle(mk(1, 5, 1), '0, 0);
    total++;
    if (wbPacket_o.valid !== 1'b1 || wbPacket_o.phyDest !== 7'd5 || wbPacket_o !== expOut) begin
      bad++;
      $display("FAIL a_latency got %h want %h", wbPacket_o, expOut);
    end
    do_cycle('0, mk(1, 9, 2), 0);
    total++;
    if (wbPacket_o.valid !== 1'b0 || bCount_o !== 3'd1) begin
      bad++;
      $display("FAIL b_latency_c1 got v=%b cnt=%0d want v=0 cnt=1", wbPacket_o.valid, bCount_o);
    end
    do_cycle('0, '0, 0);
    total++;
    if (wbPacket_o.phyDest !== 7'd9 || wbPacket_o !== expOut || bCount_o !== 3'd0) begin
      bad++;
      $display("FAIL b_latency_c2 got %h cnt=%0d want %h cnt=0", wbPacket_o, bCount_o, expOut);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        total++;
        if (bCount_o !== 3'd4 || bReady_o !== 1'b0) begin
          bad++;
          $display("FAIL fill_full got cnt=%0d bRdy=%b want 4 0", bCount_o, bReady_o);
        end
      end
      do_cycle(mk(1, 20 + i, i), mk(1, 40 + i, i), 0);
      total++;
      if (wbPacket_o !== expOut) begin
        bad++;
        $display("FAIL fill_out%0d got %h want %h", i, wbPacket_o, expOut);
      end
    end
    total++;
    if (bCount_o !== 3'd4 || bq.size() != 4) begin
      bad++;
      $display("FAIL fill_reject got cnt=%0d want 4", bCount_o);
    end
    for (int k = 0; k < 4; k++) begin
      do_cycle('0, '0, 0);
      total++;
      if (wbPacket_o.phyDest !== 7'(40 + k) || wbPacket_o !== expOut) begin
        bad++;
        $display("FAIL fill_drain%0d got %h want dest %0d", k, wbPacket_o, 40 + k);
      end
    end
  endtask

  task automatic test_starve();
    do_cycle(mk(1, 60, 0), mk(1, 70, 0), 0);
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (aReady_o !== 1'b1) begin
        bad++;
        $display("FAIL starve_ardy%0d got %b want 1", k, aReady_o);
      end
      do_cycle(mk(1, 60 + k, k), '0, 0);
      total++;
      if (wbPacket_o.phyDest !== 7'(60 + k) || wbPacket_o !== expOut) begin
        bad++;
        $display("FAIL starve_a%0d got %h want dest %0d", k, wbPacket_o, 60 + k);
      end
    end
    total++;
    if (aReady_o !== 1'b0) begin
      bad++;
      $display("FAIL starve_block got aRdy=%b want 0", aReady_o);
    end
    do_cycle(mk(1, 65, 5), '0, 0);
    total++;
    if (wbPacket_o.phyDest !== 7'd70 || wbPacket_o !== expOut) begin
      bad++;
      $display("FAIL starve_b got %h want dest 70", wbPacket_o);
    end
    do_cycle(mk(1, 66, 6), '0, 0);
    total++;
    if (aReady_o !== 1'b1 || wbPacket_o.phyDest !== 7'd66) begin
      bad++;
      $display("FAIL starve_resume got aRdy=%b dest=%0d want 1 66", aReady_o, wbPacket_o.phyDest);
    end
  endtask

  task automatic test_recover();
    for (int i = 0; i < 3; i++) do_cycle(mk(1, 80 + i, i), mk(1, 90 + i, i), 0);
    total++;
    if (bCount_o !== 3'd3) begin
      bad++;
      $display("FAIL recover_pre got cnt=%0d want 3", bCount_o);
    end
    do_cycle(mk(1, 85, 5), mk(1, 95, 5), 1);
    total++;
    if (bCount_o !== 3'd0 || wbPacket_o !== '0) begin
      bad++;
      $display("FAIL recover_flush got cnt=%0d pkt=%h want 0 0", bCount_o, wbPacket_o);
    end
    for (int k = 0; k < 3; k++) begin
      do_cycle('0, '0, 0);
      total++;
      if (wbPacket_o.valid !== 1'b0 || bCount_o !== 3'd0) begin
        bad++;
        $display("FAIL recover_idle%0d got %h cnt=%0d want 0 0", k, wbPacket_o, bCount_o);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) do_cycle(mk(1, 100 + i, i), mk(1, 110 + i, i), 0);
    for (int r = 0; r < 6; r++) begin
      do_cycle('0, mk(1, 120 + r, r), 0);
      do_cycle(mk(1, 100, r), mk(1, 120 + r, r), 0);
      total++;
      if (bCount_o !== 3'd4 || bCount_o !== 3'(bq.size())) begin
        bad++;
        $display("FAIL wrap_cnt%0d got %0d want 4", r, bCount_o);
      end
    end
    for (int k = 0; k < 4; k++) begin
      do_cycle('0, '0, 0);
      total++;
      if (wbPacket_o !== expOut || wbPacket_o.valid !== 1'b1) begin
        bad++;
        $display("FAIL wrap_drain%0d got %h want %h", k, wbPacket_o, expOut);
      end
    end
  endtask

  task automatic test_async_reset();
    do_cycle(mk(1, 30, 1), mk(1, 31, 1), 0);
    do_cycle(mk(1, 32, 2), mk(1, 33, 2), 0);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (wbPacket_o !== '0 || bCount_o !== 3'd0 || aReady_o !== 1'b1 || bReady_o !== 1'b1) begin
      bad++;
      $display("FAIL async_reset got pkt=%h cnt=%0d aRdy=%b bRdy=%b want 0 0 1 1",
               wbPacket_o, bCount_o, aReady_o, bReady_o);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    do_cycle('0, '0, 0);
    total++;
    if (wbPacket_o.valid !== 1'b0 || bCount_o !== 3'd0) begin
      bad++;
      $display("FAIL async_release got v=%b cnt=%0d want 0 0", wbPacket_o.valid, bCount_o);
    end
  endtask

  task automatic test_random();
    wbPkt a, b;
    bit   rec;
    for (int n = 0; n < 600; n++) begin
      a   = rnd(($urandom_range(0, 3) != 0));
      b   = rnd(($urandom_range(0, 2) != 0));
      rec = ($urandom_range(0, 40) == 0);
      total++;
      if (aReady_o !== m_a_rdy() || bReady_o !== m_b_rdy()) begin
        bad++;
        $display("FAIL rand_ready%0d got aRdy=%b bRdy=%b want %b %b",
                 n, aReady_o, bReady_o, m_a_rdy(), m_b_rdy());
      end
      do_cycle(a, b, rec);
      total++;
      if (wbPacket_o !== expOut || bCount_o !== 3'(bq.size())) begin
        bad++;
        $display("FAIL rand_out%0d got %h cnt=%0d want %h cnt=%0d",
                 n, wbPacket_o, bCount_o, expOut, bq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_starve();
    test_recover();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_result_arbiter.md
WB_RESULT_ARBITER -- requirements
Module: wb_result_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of entries in the B-source result FIFO (power of two).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive A-wins with B pending before B is forced.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the reset; asynchronous and active-low (0 = reset asserted).
REQ-005 SHALL have port recoverFlag_i  input  1  meaning the pipeline recovery flush.
REQ-006 SHALL have port aPacket_i  input  wbPkt (`WB_PKT_SIZE)  meaning the single-cycle FU result; offered when .valid=1.
REQ-007 SHALL have port aReady_o  output  1  meaning A result accepted this cycle if aPacket_i.valid=1.
REQ-008 SHALL have port bPacket_i  input  wbPkt (`WB_PKT_SIZE)  meaning the multi-cycle FU result; offered when .valid=1.
REQ-009 SHALL have port bReady_o  output  1  meaning B result enqueued this cycle if bPacket_i.valid=1.
REQ-010 SHALL have port wbPacket_o  output  wbPkt (`WB_PKT_SIZE)  meaning the registered packet driven to the writeback control stage.
REQ-011 SHALL have port bCount_o  output  log2(DEPTH)+1  meaning current B FIFO occupancy.

Function
REQ-012 SHALL hold a DEPTH-entry circular FIFO with read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus an occupancy count 0..DEPTH.
REQ-013 SHALL drive bReady_o = (count != DEPTH), from registered count only; no same-cycle pop credit.
REQ-014 SHALL enqueue bPacket_i at the write pointer when bPacket_i.valid & bReady_o & !recoverFlag_i, even when the FIFO is empty (no B bypass).
REQ-015 SHALL hold a starvation counter (0..STARVE_LIMIT); starve mode = (counter == STARVE_LIMIT) & (count != 0).
REQ-016 SHALL drive aReady_o = !starve mode, from registered state only.
REQ-017 SHALL select per cycle, priority order: (a) recoverFlag_i -> nothing; (b) A accepted -> A; (c) count != 0 -> FIFO head, popped; (d) else nothing.
REQ-018 SHALL load wbPacket_o at the clock edge with the selected packet, or all-zero when nothing is selected; A latency 1 cycle, B latency minimum 2 cycles.
REQ-019 SHALL increment the starvation counter when A is selected while count != 0; clear it when a B pop occurs or count == 0.
REQ-020 SHALL, with a simultaneous enqueue and pop, keep count unchanged and advance both pointers.
REQ-021 SHALL, when DEPTH entries are full and A wins, keep the FIFO full with bReady_o low; no entry is dropped or overwritten.
REQ-022 SHALL, when recoverFlag_i=1, at that edge clear pointers, count and starvation counter, zero wbPacket_o, and discard both inputs regardless of ready.
REQ-023 SHALL never issue more than one valid packet on wbPacket_o per cycle and SHALL preserve B FIFO order.

Reset
REQ-024 SHALL, while reset=0, asynchronously force pointers, count, starvation counter and wbPacket_o to zero.
REQ-025 SHALL present aReady_o=1, bReady_o=1, bCount_o=0, wbPacket_o.valid=0 during and after reset until the first accepted input.
REQ-026 SHALL, on reset assertion mid-operation, discard all queued B entries and the in-flight output with no partial state retained.

Verification
REQ-027 SHALL cover: A valid (phyDest=5) at cycle 0, FIFO empty -> wbPacket_o.valid=1, phyDest=5 at cycle 1; B valid (phyDest=9) at cycle 0 alone -> wbPacket_o phyDest=9 at cycle 2.
REQ-028 SHALL cover: 4 B pushes with A idle held off by A traffic -> bCount_o=4, bReady_o=0; 5th B offered is not accepted; drain order matches push order.
REQ-029 SHALL cover: 1 B queued, A valid every cycle -> A out 4 cycles, then aReady_o=0 one cycle and B out, then A resumes.
REQ-030 SHALL cover: 3 B queued, recoverFlag_i=1 with A and B valid -> next cycle bCount_o=0, wbPacket_o all zero, neither input appears later.
REQ-031 SHALL cover: FIFO full, B pop with new B offered next cycle -> count returns to 4, pointers wrap past DEPTH-1 to 0 with correct order.
REQ-032 SHALL cover: reset driven low mid-stream with 2 B queued -> outputs zero immediately (asynchronous), FIFO empty after release.
